io_bank_latch: RTL and testbench

//  Z80 I/O-port bank register for the Laser 310 64K expansion. Captures an OUT to BANK_PORT,

---
 rtl/io_bank_latch.sv | 110 +++++++++++
 tb/tb_io_bank_latch.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/io_bank_latch.sv
// Z80 I/O-port bank register: synchronises the bus strobes, glitch-filters OUT writes through a
// small FSM, and exposes the bank number, a sticky lock bit and an IN readback path.
module io_bank_latch #(
  parameter logic [7:0] BANK_PORT   = 8'h70,
  parameter int         BANK_W      = 2,
  parameter int         SYNC_STAGES = 2,
  parameter int         SETTLE      = 2
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [7:0]        Addr,
  input  logic [7:0]        D,
  input  logic              IORQ_N,
  input  logic              WR_N,
  input  logic              RD_N,
  input  logic              M1_N,
  output logic [BANK_W-1:0] BANK,
  output logic              BANK_LOCK,
  output logic              BANK_STB,
  output logic [7:0]        DOUT,
  output logic              DOUT_OE
);

  localparam int CMAX = (SYNC_STAGES > SETTLE) ? SYNC_STAGES : SETTLE;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {S_BOOT, S_WAIT_END, S_IDLE, S_SETTLE, S_COMMIT} state_e;

  state_e                      state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [3:0][SYNC_STAGES-1:0] sync_q;
  logic [3:0]                  strb_in;
  logic [BANK_W-1:0]           bank_q;
  logic                        lock_q, stb_q, oe_q, commit;
  logic                        sIORQ_N, sWR_N, sRD_N, sM1_N;
  logic                        port_hit, wr_act, rd_act;
  logic                        unused_d;

  assign strb_in = {M1_N, RD_N, WR_N, IORQ_N};

  // Idle-high synchronisers; reset to 1 so nothing looks active out of reset.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) sync_q <= '1;
    else for (int i = 0; i < 4; i++)
      sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], strb_in[i]};
  end

  assign sIORQ_N  = sync_q[0][SYNC_STAGES-1];
  assign sWR_N    = sync_q[1][SYNC_STAGES-1];
  assign sRD_N    = sync_q[2][SYNC_STAGES-1];
  assign sM1_N    = sync_q[3][SYNC_STAGES-1];
  assign port_hit = (Addr == BANK_PORT);
  assign wr_act   = !sIORQ_N && !sWR_N && sRD_N && sM1_N && port_hit;
  assign rd_act   = !sIORQ_N && !sRD_N && sWR_N && sM1_N && port_hit;
  assign unused_d = ^D[6:BANK_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      S_BOOT:
        if (cnt_q == '0) state_d = S_WAIT_END;
        else             cnt_d   = cnt_q - 1'b1;
      // A strobe must be seen released before another write can start.
      S_WAIT_END:
        if (sIORQ_N || sWR_N) state_d = S_IDLE;
      S_IDLE:
        if (wr_act) begin
          state_d = S_SETTLE;
          cnt_d   = CW'(SETTLE - 1);
        end
      S_SETTLE:
        if (!wr_act) state_d = S_IDLE;
        else if (cnt_q == '0) begin
          state_d = S_COMMIT;
          commit  = 1'b1;
        end else cnt_d = cnt_q - 1'b1;
      S_COMMIT: state_d = S_WAIT_END;
      default:  state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_BOOT;
      cnt_q   <= CW'(SYNC_STAGES - 1);
      bank_q  <= '0;
      lock_q  <= 1'b0;
      stb_q   <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stb_q   <= commit && !lock_q;
      oe_q    <= rd_act;
      if (commit && !lock_q) begin
        bank_q <= D[BANK_W-1:0];
        lock_q <= D[7];
      end
    end
  end

  assign BANK      = bank_q;
  assign BANK_LOCK = lock_q;
  assign BANK_STB  = stb_q;
  assign DOUT_OE   = oe_q;
  assign DOUT      = {lock_q, {(7-BANK_W){1'b0}}, bank_q};

endmodule

// File: tb/tb_io_bank_latch.sv
// Directed and randomized bench for io_bank_latch; a transaction-level model predicts the bank
// register contents and the number of update strobes each bus cycle should produce.
module tb_io_bank_latch;

  localparam int SETTLE = 2;

  logic       CLK, RESET_N;
  logic [7:0] Addr, D;
  logic       IORQ_N, WR_N, RD_N, M1_N;
  logic [1:0] BANK;
  logic       BANK_LOCK, BANK_STB, DOUT_OE;
  logic [7:0] DOUT;

  int checks = 0;
  int errors = 0;
  int stb_total = 0;

  logic [1:0] m_bank;
  logic       m_lock;

  io_bank_latch dut (
    .CLK(CLK), .RESET_N(RESET_N), .Addr(Addr), .D(D),
    .IORQ_N(IORQ_N), .WR_N(WR_N), .RD_N(RD_N), .M1_N(M1_N),
    .BANK(BANK), .BANK_LOCK(BANK_LOCK), .BANK_STB(BANK_STB),
    .DOUT(DOUT), .DOUT_OE(DOUT_OE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    #1;
    if (BANK_STB === 1'b1) stb_total++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    IORQ_N = 1'b1; WR_N = 1'b1; RD_N = 1'b1; M1_N = 1'b1;
  endtask

  // mode: 0 = OUT, 1 = interrupt ack (M1 low), 2 = RD and WR both low, 3 = IN
  task automatic bus_op(input logic [7:0] a, input logic [7:0] d, input int mode, input int len);
    Addr   = a;
    D      = d;
    IORQ_N = 1'b0;
    WR_N   = (mode == 3);
    RD_N   = !(mode == 2 || mode == 3);
    M1_N   = (mode != 1);
    repeat (len) @(negedge CLK);
    idle_bus();
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    m_bank = '0;
    m_lock = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  // Model: an OUT to 70h with M1 high and RD high commits when the strobe is sampled low on
  // at least SETTLE+1 edges (visible after sync, then SETTLE confirmations), unless locked.
  function automatic bit commits(input logic [7:0] a, input int mode, input int len);
    return (a == 8'h70) && (mode == 0) && (len >= SETTLE + 1) && !m_lock;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, " bank"}, BANK, m_bank);
    chk({tag, " lock"}, BANK_LOCK, m_lock);
    chk({tag, " dout"}, DOUT, {m_lock, 5'b0, m_bank});
  endtask

  initial begin
    int s0;
    logic [7:0] a, d;
    int mode, len;
    bit c;

    RESET_N = 1'b1; Addr = 8'h00; D = 8'h00;
    idle_bus();
    #2 RESET_N = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst bank", BANK, 2'd0);
    chk("rst lock", BANK_LOCK, 1'b0);
    chk("rst stb", BANK_STB, 1'b0);
    chk("rst dout", DOUT, 8'h00);
    chk("rst oe", DOUT_OE, 1'b0);
    RESET_N = 1'b1;
    m_bank = '0; m_lock = 1'b0;
    repeat (4) @(negedge CLK);

    // Latency: BANK changes on the 5th edge, strobe pulses exactly once.
    s0 = stb_total;
    Addr = 8'h70; D = 8'h02; IORQ_N = 1'b0; WR_N = 1'b0;
    repeat (4) @(negedge CLK);
    chk("lat edge4 bank", BANK, 2'd0);
    chk("lat edge4 stb", BANK_STB, 1'b0);
    @(negedge CLK);
    chk("lat edge5 bank", BANK, 2'd2);
    chk("lat edge5 stb", BANK_STB, 1'b1);
    chk("lat edge5 lock", BANK_LOCK, 1'b0);
    @(negedge CLK);
    chk("lat edge6 stb", BANK_STB, 1'b0);
    repeat (2) @(negedge CLK);
    idle_bus();
    repeat (8) @(negedge CLK);
    chk("lat stb count", stb_total - s0, 1);
    m_bank = 2'd2;

    // Glitch rejection and non-matching cycles.
    s0 = stb_total;
    bus_op(8'h70, 8'h03, 0, 1); repeat (8) @(negedge CLK);
    check_state("glitch1");
    bus_op(8'h70, 8'h03, 0, 2); repeat (8) @(negedge CLK);
    check_state("glitch2");
    bus_op(8'h71, 8'h03, 0, 8); repeat (8) @(negedge CLK);
    check_state("port71");
    bus_op(8'h70, 8'h03, 1, 8); repeat (8) @(negedge CLK);
    check_state("intack");
    bus_op(8'h70, 8'h03, 2, 8); repeat (8) @(negedge CLK);
    check_state("rdwr low");
    chk("reject stb count", stb_total - s0, 0);

    // Lock, then a locked write, then readback.
    bus_op(8'h70, 8'h81, 0, 6); repeat (8) @(negedge CLK);
    m_bank = 2'd1; m_lock = 1'b1;
    check_state("lock set");
    s0 = stb_total;
    bus_op(8'h70, 8'h03, 0, 6); repeat (8) @(negedge CLK);
    check_state("locked wr");
    chk("locked stb count", stb_total - s0, 0);
    Addr = 8'h70; IORQ_N = 1'b0; RD_N = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rd oe early", DOUT_OE, 1'b0);
    @(negedge CLK);
    chk("rd oe", DOUT_OE, 1'b1);
    chk("rd dout", DOUT, 8'h81);
    repeat (2) @(negedge CLK);
    idle_bus();
    repeat (3) @(negedge CLK);
    chk("rd oe release", DOUT_OE, 1'b0);
    do_reset();
    check_state("unlock rst");

    // Reset mid-SETTLE, released with the strobe still low.
    bus_op(8'h70, 8'h01, 0, 6); repeat (8) @(negedge CLK);
    m_bank = 2'd1;
    check_state("pre midrst");
    s0 = stb_total;
    Addr = 8'h70; D = 8'h02; IORQ_N = 1'b0; WR_N = 1'b0;
    repeat (4) @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    chk("midrst bank", BANK, 2'd0);
    chk("midrst stb", BANK_STB, 1'b0);
    chk("midrst dout", DOUT, 8'h00);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    m_bank = '0; m_lock = 1'b0;
    repeat (8) @(negedge CLK);
    idle_bus();
    repeat (8) @(negedge CLK);
    check_state("midrst held");
    chk("midrst stb count", stb_total - s0, 0);
    bus_op(8'h70, 8'h02, 0, 8); repeat (8) @(negedge CLK);
    m_bank = 2'd2;
    check_state("midrst reissue");

    // Randomized transactions against the model.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 9) == 0) do_reset();
      a    = ($urandom_range(0, 3) == 0) ? 8'h71 : 8'h70;
      d    = 8'($urandom);
      if ($urandom_range(0, 3) != 0) d[7] = 1'b0;
      mode = ($urandom_range(0, 4) < 3) ? 0 : int'($urandom_range(1, 3));
      len  = int'($urandom_range(1, 6));
      c    = commits(a, mode, len);
      s0   = stb_total;
      bus_op(a, d, mode, len);
      repeat (8) @(negedge CLK);
      if (c) begin
        m_bank = d[1:0];
        m_lock = d[7];
      end
      check_state("rand");
      chk("rand stb count", stb_total - s0, c ? 1 : 0);
      chk("rand oe idle", DOUT_OE, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
